// File: rtl/weight_export_control.sv
// Reads trained weights out of the weighted layers group by group and serialises them as a
// valid/ready stream of 32-bit words for federated upload.
module weight_export_control #(
  parameter int unsigned MAX_NUM_NEURONS   = 4,
  parameter int unsigned ACTIVE_NEURONS    = 3,
  parameter int unsigned NUM_WEIGHTS       = 4,
  parameter int unsigned NUM_WEIGHT_LAYERS = 2,
  parameter int unsigned READ_LATENCY      = 1,
  parameter logic [1:0]  LAYER_STATE_READ  = 2'b11
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [32*MAX_NUM_NEURONS-1:0]        neurons_weight,
  output logic [$clog2(NUM_WEIGHTS)-1:0]       weight_memory_address,
  output logic [NUM_WEIGHT_LAYERS-1:0]         enable_layers,
  output logic [1:0]                           layer_state,
  output logic [31:0]                          weight_data,
  output logic                                 weight_valid,
  input  logic                                 weight_ready,
  output logic                                 weight_last,
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned AW = $clog2(NUM_WEIGHTS);
  localparam int unsigned NW = (MAX_NUM_NEURONS > 1) ? $clog2(MAX_NUM_NEURONS) : 1;
  localparam int unsigned LW = (NUM_WEIGHT_LAYERS > 1) ? $clog2(NUM_WEIGHT_LAYERS) : 1;
  localparam int unsigned WW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [AW-1:0] LastAddr   = AW'(NUM_WEIGHTS - 1);
  localparam logic [NW-1:0] LastNeuron = NW'(ACTIVE_NEURONS - 1);
  localparam logic [LW-1:0] LastLayer  = LW'(NUM_WEIGHT_LAYERS - 1);
  localparam logic [WW-1:0] LastWait   = WW'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StCapture,
    StSend,
    StDone
  } state_e;

  state_e                             state_q, state_d;
  logic [LW-1:0]                      layer_q, layer_d;
  logic [AW-1:0]                      addr_q, addr_d;
  logic [NW-1:0]                      neuron_q, neuron_d;
  logic [WW-1:0]                      wait_q, wait_d;
  logic                               capture_en;
  logic [MAX_NUM_NEURONS-1:0][31:0]   shadow_q;
  logic                               in_group;
  logic                               group_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      layer_q  <= '0;
      addr_q   <= '0;
      neuron_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      addr_q   <= addr_d;
      neuron_q <= neuron_d;
      wait_q   <= wait_d;
    end
  end

  // Shadow copy lets the sink stall arbitrarily without re-reading the layers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
    end else if (capture_en) begin
      shadow_q <= neurons_weight;
    end
  end

  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    addr_d     = addr_q;
    neuron_d   = neuron_q;
    wait_d     = wait_q;
    capture_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StSetup;
          layer_d  = '0;
          addr_d   = '0;
          neuron_d = '0;
          wait_d   = '0;
        end
      end
      StSetup: begin
        if (wait_q == LastWait) begin
          wait_d  = '0;
          state_d = StCapture;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StCapture: begin
        capture_en = 1'b1;
        state_d    = StSend;
      end
      StSend: begin
        if (weight_ready) begin
          if (neuron_q == LastNeuron) begin
            neuron_d = '0;
            if (addr_q == LastAddr) begin
              addr_d = '0;
              if (layer_q == LastLayer) begin
                state_d = StDone;
              end else begin
                layer_d = layer_q + 1'b1;
                state_d = StSetup;
              end
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = StSetup;
            end
          end else begin
            neuron_d = neuron_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign in_group   = (state_q == StSetup) || (state_q == StCapture) || (state_q == StSend);
  assign group_last = (addr_q == LastAddr) && (layer_q == LastLayer);

  always_comb begin
    busy                  = in_group;
    done                  = (state_q == StDone);
    weight_valid          = (state_q == StSend);
    weight_last           = 1'b0;
    weight_data           = '0;
    weight_memory_address = '0;
    enable_layers         = '0;
    layer_state           = 2'b00;
    if (in_group) begin
      weight_memory_address = addr_q;
      enable_layers         = NUM_WEIGHT_LAYERS'(1) << layer_q;
      layer_state           = LAYER_STATE_READ;
    end
    if (state_q == StSend) begin
      weight_data = shadow_q[neuron_q];
      weight_last = group_last && (neuron_q == LastNeuron);
    end
  end

endmodule

// File: tb/tb_weight_export_control.sv
// Randomised self-checking bench for weight_export_control with a word-order reference model.
module tb_weight_export_control;

  localparam int MN = 4;
  localparam int AN = 3;
  localparam int NWT = 4;
  localparam int NL = 2;
  localparam int TOTAL = NL * NWT * AN;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic         start1, ready1, start2, ready2;
  logic [127:0] nw1, nw2, p1, p2, p3;
  logic [1:0]   addr1, addr2, en1, en2, ls1, ls2;
  logic [31:0]  wd1, wd2;
  logic         wv1, wv2, wl1, wl2, busy1, busy2, done1, done2;

  int checks = 0;
  int errors = 0;

  weight_export_control dut1 (
    .clock(clock), .reset(reset), .start(start1), .neurons_weight(nw1),
    .weight_memory_address(addr1), .enable_layers(en1), .layer_state(ls1),
    .weight_data(wd1), .weight_valid(wv1), .weight_ready(ready1), .weight_last(wl1),
    .busy(busy1), .done(done1)
  );

  weight_export_control #(.READ_LATENCY(3)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .neurons_weight(nw2),
    .weight_memory_address(addr2), .enable_layers(en2), .layer_state(ls2),
    .weight_data(wd2), .weight_valid(wv2), .weight_ready(ready2), .weight_last(wl2),
    .busy(busy2), .done(done2)
  );

  // Layer model: slot n returns 32'h00LLAANN; garbage when no layer is enabled.
  function automatic logic [127:0] model_bus(input logic [1:0] addr, input logic [1:0] en);
    logic [127:0] b;
    int l;
    if (en == 2'b00) return {4{32'hBAD0BAD0}};
    l = (en == 2'b10) ? 1 : 0;
    for (int n = 0; n < MN; n++) b[n*32 +: 32] = {8'h00, 8'(l), 6'h0, addr, 8'(n)};
    return b;
  endfunction

  always @(posedge clock) begin
    nw1 <= model_bus(addr1, en1);
    p1  <= model_bus(addr2, en2);
    p2  <= p1;
    p3  <= p2;
  end
  // Bus is corrupted once the second DUT is streaming, i.e. after its capture.
  assign nw2 = wv2 ? ~p3 : p3;

  function automatic logic [31:0] exp_word(input int idx);
    int l, a, n;
    l = idx / (NWT * AN);
    a = (idx / AN) % NWT;
    n = idx % AN;
    return {8'h00, 8'(l), 8'(a), 8'(n)};
  endfunction

  logic [31:0] words_q[$];
  bit          last_q[$];
  int          acc_q[$];
  int          first_valid, done_cycle, done_cnt, viol;
  bit          timed_out;
  bit          busy_log[256];

  task automatic do_reset();
    reset = 1'b1;
    start1 = 1'b0; ready1 = 1'b0; start2 = 1'b0; ready2 = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Drives one export on dut1 and records what crosses the handshake.
  task automatic collect1(input int low_pct, input int restart, input bit hold, input int max_cyc);
    logic [31:0] pd;
    logic [1:0]  pa;
    bit          pl, prev_stall;
    words_q.delete(); last_q.delete(); acc_q.delete();
    first_valid = -1; done_cycle = -1; done_cnt = 0; viol = 0; timed_out = 1'b1;
    prev_stall = 1'b0; pd = '0; pa = '0; pl = 1'b0;
    for (int i = 0; i < 256; i++) busy_log[i] = 1'b0;
    for (int rel = 0; rel < max_cyc; rel++) begin
      start1 = hold || (rel == 0) || (rel == restart);
      ready1 = ($urandom_range(99) >= low_pct);
      @(negedge clock);
      if (rel < 256) busy_log[rel] = busy1;
      if (wv1 && first_valid < 0) first_valid = rel;
      if (prev_stall && (!wv1 || wd1 !== pd || wl1 !== pl || addr1 !== pa)) viol++;
      prev_stall = wv1 && !ready1;
      pd = wd1; pl = wl1; pa = addr1;
      if (wv1 && ready1) begin
        words_q.push_back(wd1); last_q.push_back(wl1); acc_q.push_back(rel);
      end
      if (done1) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = rel;
      end
      if (done_cycle >= 0 && rel >= done_cycle + 2) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clock);
      #1;
    end
    start1 = 1'b0;
    ready1 = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic check_stream(input string tag);
    checks++;
    if (timed_out !== 1'b0) begin
      errors++; $display("FAIL %s_timeout got %0d want 0", tag, timed_out);
    end
    checks++;
    if (words_q.size() !== TOTAL) begin
      errors++; $display("FAIL %s_count got %0d want %0d", tag, words_q.size(), TOTAL);
    end
    for (int i = 0; i < words_q.size() && i < TOTAL; i++) begin
      checks++;
      if (words_q[i] !== exp_word(i)) begin
        errors++; $display("FAIL %s_word%0d got %h want %h", tag, i, words_q[i], exp_word(i));
      end
      checks++;
      if (last_q[i] !== (i == TOTAL - 1)) begin
        errors++; $display("FAIL %s_last%0d got %0d want %0d", tag, i, last_q[i], i == TOTAL - 1);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start1 = 1'b0; ready1 = 1'b0; start2 = 1'b0; ready2 = 1'b0;
    #3;
    checks++;
    if ({addr1, en1, ls1, wd1, wv1, wl1, busy1, done1} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0",
                         {addr1, en1, ls1, wd1, wv1, wl1, busy1, done1});
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy1, wv1, done1, ls1} !== '0) begin
      errors++; $display("FAIL reset_idle got %h want 0", {busy1, wv1, done1, ls1});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_full_rate();
    do_reset();
    collect1(0, -1, 1'b0, 200);
    check_stream("full");
    checks++;
    if (first_valid !== 3) begin
      errors++; $display("FAIL full_first_valid got %0d want 3", first_valid);
    end
    checks++;
    if (acc_q.size() != TOTAL || acc_q[TOTAL-1] !== 40) begin
      errors++; $display("FAIL full_last_accept got %0d want 40",
                         acc_q.size() ? acc_q[acc_q.size()-1] : -1);
    end
    checks++;
    if (done_cycle !== 41 || done_cnt !== 1) begin
      errors++; $display("FAIL full_done got cyc %0d cnt %0d want cyc 41 cnt 1", done_cycle, done_cnt);
    end
    checks++;
    if ({busy_log[1], busy_log[40], busy_log[41], busy_log[0]} !== 4'b1100) begin
      errors++; $display("FAIL full_busy got %b want 1100",
                         {busy_log[1], busy_log[40], busy_log[41], busy_log[0]});
    end
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 2; r++) begin
      do_reset();
      collect1(30, -1, 1'b0, 800);
      check_stream("bp");
      checks++;
      if (viol !== 0) begin
        errors++; $display("FAIL bp_stall_stable got %0d want 0", viol);
      end
      checks++;
      if (done_cnt !== 1) begin
        errors++; $display("FAIL bp_done_count got %0d want 1", done_cnt);
      end
    end
  endtask

  task automatic test_start_ignored();
    do_reset();
    collect1(0, 10, 1'b0, 200);
    check_stream("restart");
    checks++;
    if (done_cycle !== 41) begin
      errors++; $display("FAIL restart_done got %0d want 41", done_cycle);
    end
    do_reset();
    collect1(0, -1, 1'b1, 200);
    checks++;
    if (done_cycle !== 41) begin
      errors++; $display("FAIL hold_done got %0d want 41", done_cycle);
    end
    checks++;
    if ({busy_log[41], busy_log[42], busy_log[43]} !== 3'b001) begin
      errors++; $display("FAIL hold_restart got %b want 001",
                         {busy_log[41], busy_log[42], busy_log[43]});
    end
  endtask

  task automatic test_reset_mid();
    int  accepted;
    bit  fired;
    do_reset();
    accepted = 0;
    fired = 1'b0;
    for (int rel = 0; rel < 200; rel++) begin
      start1 = (rel == 0);
      ready1 = (accepted < 9);
      @(negedge clock);
      if (wv1 && ready1) begin
        accepted++;
      end else if (wv1 && accepted == 9) begin
        checks++;
        if (wd1 !== exp_word(9)) begin
          errors++; $display("FAIL mid_pending got %h want %h", wd1, exp_word(9));
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({addr1, en1, ls1, wd1, wv1, wl1, busy1, done1} !== '0) begin
          errors++; $display("FAIL mid_async_reset got %h want 0",
                             {addr1, en1, ls1, wd1, wv1, wl1, busy1, done1});
        end
        fired = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    checks++;
    if (!fired) begin
      errors++; $display("FAIL mid_reach_word10 got 0 want 1");
    end
    start1 = 1'b0;
    ready1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (done1 !== 1'b0) begin
        errors++; $display("FAIL mid_no_done got %0d want 0", done1);
      end
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    collect1(0, -1, 1'b0, 200);
    check_stream("after_reset");
  endtask

  task automatic test_latency3();
    logic [31:0] got[$];
    int fv, dc;
    do_reset();
    fv = -1;
    dc = -1;
    for (int rel = 0; rel < 300; rel++) begin
      start2 = (rel == 0);
      ready2 = 1'b1;
      @(negedge clock);
      if (wv2 && fv < 0) fv = rel;
      if (wv2 && ready2) got.push_back(wd2);
      if (done2) begin
        dc = rel;
        break;
      end
      @(posedge clock);
      #1;
    end
    start2 = 1'b0;
    ready2 = 1'b0;
    checks++;
    if (fv !== 5) begin
      errors++; $display("FAIL lat3_first_valid got %0d want 5", fv);
    end
    checks++;
    if (dc !== NL * NWT * (3 + 1 + AN) + 1) begin
      errors++; $display("FAIL lat3_done got %0d want %0d", dc, NL * NWT * (3 + 1 + AN) + 1);
    end
    checks++;
    if (got.size() !== TOTAL) begin
      errors++; $display("FAIL lat3_count got %0d want %0d", got.size(), TOTAL);
    end
    for (int i = 0; i < got.size() && i < TOTAL; i++) begin
      checks++;
      if (got[i] !== exp_word(i)) begin
        errors++; $display("FAIL lat3_word%0d got %h want %h", i, got[i], exp_word(i));
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    start1 = 1'b0; ready1 = 1'b0; start2 = 1'b0; ready2 = 1'b0;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_latency3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_export_control.md
# weight_export_control

Sequencer that reads trained weights back out of the weighted layers (hidden, softmax output) for federated upload to the aggregator. It drives `weight_memory_address`, `enable_layers` and `layer_state` into the layers, captures the returned `neurons_weight` bus and serialises it as a stream of 32-bit float words over a valid/ready handshake. It sits beside `layer_control` and owns the layer control inputs only while `busy` is high.

## Interface
- `MAX_NUM_NEURONS`, 4: neuron slots on the `neurons_weight` bus.
- `ACTIVE_NEURONS`, 3: neurons exported per layer; slots 0..ACTIVE_NEURONS-1.
- `NUM_WEIGHTS`, 4: weight addresses per neuron, 0..NUM_WEIGHTS-1.
- `NUM_WEIGHT_LAYERS`, 2: weighted layers exported; layer 0 = hidden, 1 = softmax output.
- `READ_LATENCY`, 1: cycles from address/enable valid to `neurons_weight` valid; must be at least 1.
- `LAYER_STATE_READ`, 2'b11: `layer_state` code that puts the layers in weight-read mode.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request an export; sampled only in IDLE.
- `neurons_weight` in 32*MAX_NUM_NEURONS: slot n = bits [32n+31:32n].
- `weight_memory_address` out $clog2(NUM_WEIGHTS): weight address to the layers.
- `enable_layers` out NUM_WEIGHT_LAYERS: one-hot select of the layer being read.
- `layer_state` out 2: LAYER_STATE_READ while busy, else 2'b00.
- `weight_data` out 32: exported word.
- `weight_valid` out 1: `weight_data` is valid.
- `weight_ready` in 1: sink accepts the word.
- `weight_last` out 1: high with the final word of the export.
- `busy` out 1: export in progress.
- `done` out 1: one-cycle pulse after the last word is accepted.

## Operation
- Stream order: layer (0 first), then address (0 first), then neuron slot (0 first). Total words = NUM_WEIGHT_LAYERS*NUM_WEIGHTS*ACTIVE_NEURONS (24 at defaults).
- FSM states:
  - IDLE: `start`=1 goes to SETUP, with layer, address and neuron counters cleared.
  - SETUP: the address and one-hot enable are driven. The block waits READ_LATENCY cycles, then goes to CAPTURE.
  - CAPTURE: the full `neurons_weight` bus is latched into a shadow register. Next state is SEND.
  - SEND: `weight_data` = shadow slot[neuron]. On a valid&&ready transfer, the neuron counter increments.
    - After slot ACTIVE_NEURONS-1 is accepted, the address increments and the next state is SETUP.
    - When the address wraps from NUM_WEIGHTS-1 to 0, the layer increments.
    - When the final layer and address are complete, the next state is DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `weight_memory_address` and `enable_layers` hold steady from SETUP through SEND of the same group.
- The shadow register decouples the stream from the layer outputs; sink backpressure never re-reads memory.
- `start` is ignored in every state except IDLE, including DONE.
- `weight_ready` is ignored when `weight_valid`=0.
- Pure data mover: no arithmetic on the words. Float bit patterns pass through unchanged.

## Timing
- Reset values:
  - all outputs 0: `weight_memory_address`, `enable_layers`, `weight_data`, `weight_valid`, `weight_last`, `busy`, `done`;
  - `layer_state`=2'b00;
  - FSM in IDLE.
- Reset mid-export: everything returns to the reset values immediately. No `done` is generated, the partial stream is abandoned, and the next `start` restarts from layer 0, address 0.
- `start` high at cycle 0 (IDLE):
  - cycle 1: SETUP, `busy`=1, address/enable/`layer_state` valid;
  - SETUP covers cycles 1..READ_LATENCY;
  - CAPTURE at cycle READ_LATENCY+1;
  - first `weight_valid` at cycle READ_LATENCY+2 (cycle 3 at defaults).
- Handshake:
  - once asserted, `weight_valid` stays high and `weight_data`/`weight_last` stay stable until accepted;
  - back-to-back transfers within a group take one cycle each;
  - `weight_valid`=0 during SETUP and CAPTURE.
- Throughput at defaults with `weight_ready` tied high: 5 cycles per address group. The last word is accepted at cycle 40; `done`=1 and `busy`=0 at cycle 41.
- `busy` is high from SETUP entry through the last SEND cycle and low in DONE and IDLE.

## Test plan
- Setup for all scenarios: the layer model returns 32'h00LLAANN (layer, address, neuron) with 1-cycle latency.
- Default parameters, `weight_ready`=1, `start` at cycle 0:
  - 24 words in order 32'h00000000, 32'h00000001, 32'h00000002, 32'h00000100 … 32'h00010302;
  - first valid at cycle 3;
  - `weight_last` only on the 24th word;
  - `done` pulse at cycle 41.
- Random `weight_ready` backpressure (about 30% low): same 24-word sequence with no drops or duplicates. `weight_data` and `weight_last` are stable while valid&&!ready. `weight_memory_address` does not change during stalls.
- Second `start` pulse at cycle 10 during an export: ignored, stream identical to the first scenario. A `start` held high through DONE begins a new export at the IDLE cycle after DONE.
- `reset` asserted while the 10th word is pending:
  - all outputs go to their reset values asynchronously;
  - no `done`;
  - the next `start` streams from 32'h00000000.
- READ_LATENCY=3:
  - first valid at cycle 5;
  - the layer model corrupts `neurons_weight` after the capture cycle, and the exported words still match the captured values.
